// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Game logic for a two-player Pong. Ball, paddles, scores and the game FSM
// advance once per video frame; the frame update is triggered when the sync
// generator reaches column 0 of row UPDATE_Y (the start of vertical blanking).
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   CounterX, CounterY  sync-generator column / row
//   btn_start           start button (async), rising edge starts a game
//   p1_up, p1_dn        left paddle buttons (async)
//   p2_up, p2_dn        right paddle buttons (async)
//   ball_x, ball_y      ball top-left corner
//   paddle1_y/2_y       paddle top edges
//   score1, score2      player scores (saturate at WIN_SCORE)
//   state               IDLE=0 SERVE=1 PLAY=2 POINT=3 GAMEOVER=4
//   frame_tick          one-clk pulse marking the per-frame update
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int UPDATE_Y     = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic       btn_start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [8:0] paddle1_y,
  output logic [8:0] paddle2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  // 12-bit working width keeps every sum/difference free of wrap before compare
  localparam logic [11:0] L_SPD        = 12'(BALL_SPEED);
  localparam logic [11:0] L_SIZE       = 12'(BALL_SIZE);
  localparam logic [11:0] L_SCR_W      = 12'(SCREEN_W);
  localparam logic [11:0] L_SCR_H      = 12'(SCREEN_H);
  localparam logic [11:0] L_PAD_H      = 12'(PADDLE_H);
  localparam logic [11:0] L_PAD_MAX    = 12'(SCREEN_H - PADDLE_H);
  localparam logic [11:0] L_STEP       = 12'(PADDLE_STEP);
  localparam logic [11:0] L_P1_X       = 12'(P1_X);
  localparam logic [11:0] L_P1_REACH   = 12'(P1_X + PADDLE_W + BALL_SPEED);
  localparam logic [11:0] L_P2_X       = 12'(P2_X);
  localparam logic [11:0] L_P2_BACK    = 12'(P2_X + PADDLE_W);
  localparam logic [11:0] L_UPD_Y      = 12'(UPDATE_Y);
  localparam logic [11:0] L_SERVE_LAST = 12'(SERVE_FRAMES - 1);
  localparam logic [9:0]  L_CTR_X      = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]  L_CTR_Y      = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [8:0]  L_PAD_MID    = 9'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [8:0]  L_BOT_Y      = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  L_P1_HIT_X   = 10'(P1_X + PADDLE_W);
  localparam logic [9:0]  L_P2_HIT_X   = 10'(P2_X - BALL_SIZE);
  localparam logic [3:0]  L_WIN        = 4'(WIN_SCORE);

  // Paddle move with clamping; pressing both or neither holds position
  function automatic logic [8:0] f_paddle_next(input logic [8:0] y, input logic up, input logic dn);
    logic [11:0] v_y;
    logic [11:0] v_res;
    v_y = {3'b000, y};
    if (up && !dn) begin
      v_res = (v_y <= L_STEP) ? 12'd0 : (v_y - L_STEP);
    end else if (dn && !up) begin
      v_res = ((v_y + L_STEP) >= L_PAD_MAX) ? L_PAD_MAX : (v_y + L_STEP);
    end else begin
      v_res = v_y;
    end
    return 9'(v_res);
  endfunction

  // Ball rows overlap paddle rows
  function automatic logic f_vhit(input logic [8:0] by, input logic [8:0] py);
    return (({3'b000, by} + L_SIZE) > {3'b000, py}) && ({3'b000, by} < ({3'b000, py} + L_PAD_H));
  endfunction

  state_t      r_state;
  logic [9:0]  r_bx;
  logic [8:0]  r_by;
  logic [8:0]  r_p1;
  logic [8:0]  r_p2;
  logic [3:0]  r_s1;
  logic [3:0]  r_s2;
  logic        r_dx_neg;
  logic        r_dy_neg;
  logic [11:0] r_cnt;
  logic        r_frame_tick;
  logic [4:0]  r_sync1;
  logic [4:0]  r_sync2;
  logic        r_start_q;

  state_t      w_state_nx;
  logic [9:0]  w_bx_nx;
  logic [8:0]  w_by_nx;
  logic [8:0]  w_p1_nx;
  logic [8:0]  w_p2_nx;
  logic [3:0]  w_s1_nx;
  logic [3:0]  w_s2_nx;
  logic        w_dx_neg_nx;
  logic        w_dy_neg_nx;
  logic [11:0] w_cnt_nx;

  // bit 4 start, 3 p1_up, 2 p1_dn, 1 p2_up, 0 p2_dn
  logic [4:0]  w_btn_raw;
  logic        w_start_evt;
  logic [11:0] w_bx_e;
  logic [11:0] w_by_e;
  logic        w_hit_l;
  logic        w_hit_r;

  assign w_btn_raw   = {btn_start, p1_up, p1_dn, p2_up, p2_dn};
  assign w_start_evt = r_sync2[4] & ~r_start_q;
  assign w_bx_e      = {2'b00, r_bx};
  assign w_by_e      = {3'b000, r_by};
  // Collision tests use the paddle positions held before this frame's move
  assign w_hit_l = r_dx_neg && (w_bx_e >= L_P1_X) && (w_bx_e <= L_P1_REACH) && f_vhit(r_by, r_p1);
  assign w_hit_r = !r_dx_neg && ((w_bx_e + L_SIZE) <= L_P2_BACK) &&
                   ((w_bx_e + L_SIZE + L_SPD) >= L_P2_X) && f_vhit(r_by, r_p2);

  assign ball_x     = r_bx;
  assign ball_y     = r_by;
  assign paddle1_y  = r_p1;
  assign paddle2_y  = r_p2;
  assign score1     = r_s1;
  assign score2     = r_s2;
  assign state      = r_state;
  assign frame_tick = r_frame_tick;

  // Button synchronizers, start edge history and frame tick generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 5'd0;
      r_sync2      <= 5'd0;
      r_start_q    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_sync1      <= w_btn_raw;
      r_sync2      <= r_sync1;
      r_start_q    <= r_sync2[4];
      r_frame_tick <= (CounterX == 10'd0) && ({3'b000, CounterY} == L_UPD_Y);
    end
  end

  // Game state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_bx     <= L_CTR_X;
      r_by     <= L_CTR_Y;
      r_p1     <= L_PAD_MID;
      r_p2     <= L_PAD_MID;
      r_s1     <= 4'd0;
      r_s2     <= 4'd0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_cnt    <= 12'd0;
    end else begin
      r_state  <= w_state_nx;
      r_bx     <= w_bx_nx;
      r_by     <= w_by_nx;
      r_p1     <= w_p1_nx;
      r_p2     <= w_p2_nx;
      r_s1     <= w_s1_nx;
      r_s2     <= w_s2_nx;
      r_dx_neg <= w_dx_neg_nx;
      r_dy_neg <= w_dy_neg_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nx  = r_state;
    w_bx_nx     = r_bx;
    w_by_nx     = r_by;
    w_p1_nx     = r_p1;
    w_p2_nx     = r_p2;
    w_s1_nx     = r_s1;
    w_s2_nx     = r_s2;
    w_dx_neg_nx = r_dx_neg;
    w_dy_neg_nx = r_dy_neg;
    w_cnt_nx    = r_cnt;
    case (r_state)
      ST_IDLE, ST_GAMEOVER: begin
        // Start acts immediately, not on the frame tick
        if (w_start_evt) begin
          w_state_nx = ST_SERVE;
          w_s1_nx    = 4'd0;
          w_s2_nx    = 4'd0;
          w_cnt_nx   = 12'd0;
          w_bx_nx    = L_CTR_X;
          w_by_nx    = L_CTR_Y;
          // A new game after GAMEOVER always serves toward P2
          w_dx_neg_nx = (r_state == ST_GAMEOVER) ? 1'b0 : r_dx_neg;
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_SERVE: begin
        if (r_frame_tick) begin
          w_bx_nx = L_CTR_X;
          w_by_nx = L_CTR_Y;
          w_p1_nx = f_paddle_next(r_p1, r_sync2[3], r_sync2[2]);
          w_p2_nx = f_paddle_next(r_p2, r_sync2[1], r_sync2[0]);
          if (r_cnt == L_SERVE_LAST) begin
            w_state_nx  = ST_PLAY;
            w_cnt_nx    = 12'd0;
            w_dy_neg_nx = 1'b0;
          end else begin
            w_cnt_nx = r_cnt + 12'd1;
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_PLAY: begin
        if (r_frame_tick) begin
          w_p1_nx = f_paddle_next(r_p1, r_sync2[3], r_sync2[2]);
          w_p2_nx = f_paddle_next(r_p2, r_sync2[1], r_sync2[0]);
          // Vertical axis: walls
          if (r_dy_neg) begin
            if (w_by_e <= L_SPD) begin
              w_by_nx     = 9'd0;
              w_dy_neg_nx = 1'b0;
            end else begin
              w_by_nx = 9'(w_by_e - L_SPD);
            end
          end else if ((w_by_e + L_SIZE + L_SPD) >= L_SCR_H) begin
            w_by_nx     = L_BOT_Y;
            w_dy_neg_nx = 1'b1;
          end else begin
            w_by_nx = 9'(w_by_e + L_SPD);
          end
          // Horizontal axis: paddle hit wins over miss; ball holds x on a miss
          if (r_dx_neg) begin
            if (w_hit_l) begin
              w_bx_nx     = L_P1_HIT_X;
              w_dx_neg_nx = 1'b0;
            end else if (w_bx_e < L_SPD) begin
              w_s2_nx     = (r_s2 < L_WIN) ? (r_s2 + 4'd1) : r_s2;
              w_dx_neg_nx = 1'b1;
              w_state_nx  = ST_POINT;
            end else begin
              w_bx_nx = 10'(w_bx_e - L_SPD);
            end
          end else begin
            if (w_hit_r) begin
              w_bx_nx     = L_P2_HIT_X;
              w_dx_neg_nx = 1'b1;
            end else if ((w_bx_e + L_SIZE + L_SPD) > L_SCR_W) begin
              w_s1_nx     = (r_s1 < L_WIN) ? (r_s1 + 4'd1) : r_s1;
              w_dx_neg_nx = 1'b0;
              w_state_nx  = ST_POINT;
            end else begin
              w_bx_nx = 10'(w_bx_e + L_SPD);
            end
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_POINT: begin
        if (r_frame_tick) begin
          if ((r_s1 == L_WIN) || (r_s2 == L_WIN)) begin
            w_state_nx = ST_GAMEOVER;
          end else begin
            w_state_nx = ST_SERVE;
            w_bx_nx    = L_CTR_X;
            w_by_nx    = L_CTR_Y;
            w_cnt_nx   = 12'd0;
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pong_game_ctrl: frame-tick vector table, start and
// paddle-clamp sequences, then randomized play against a behavioural model.
module tb_pong_game_ctrl;

  localparam int W = 640, H = 480, PH = 64, PW = 8, STEP = 4, SZ = 8, SPD = 2;
  localparam int P1X = 16, P2X = 616, WIN = 9, SF = 60;
  localparam int CX = 316, CY = 236, PMID = 208;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;
  localparam int MAXF = 15000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       btn_start, p1_up, p1_dn, p2_up, p2_dn;
  logic [9:0] ball_x;
  logic [8:0] ball_y, paddle1_y, paddle2_y;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic       frame_tick;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .CounterX(CounterX), .CounterY(CounterY),
    .btn_start(btn_start), .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .score1(score1), .score2(score2), .state(state), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers, signed directions)
  int m_state, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_dx, m_dy, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int pad_move(input int p, input bit up, input bit dn);
    int q;
    q = p + STEP * (int'(dn) - int'(up));
    if (q < 0) q = 0;
    if (q > H - PH) q = H - PH;
    return q;
  endfunction

  function automatic bit overlap(input int by, input int py);
    return (by + SZ > py) && (by < py + PH);
  endfunction

  task automatic m_reset();
    m_state = S_IDLE; m_bx = CX; m_by = CY; m_p1 = PMID; m_p2 = PMID;
    m_s1 = 0; m_s2 = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
  endtask

  task automatic m_start();
    if (m_state == S_IDLE || m_state == S_OVER) begin
      if (m_state == S_OVER) m_dx = 1;
      m_state = S_SERVE; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_bx = CX; m_by = CY;
    end
  endtask

  task automatic m_tick(input bit u1, input bit d1, input bit u2, input bit d2);
    int nx, ny, op1, op2;
    op1 = m_p1; op2 = m_p2;
    case (m_state)
      S_SERVE: begin
        m_bx = CX; m_by = CY;
        m_p1 = pad_move(m_p1, u1, d1); m_p2 = pad_move(m_p2, u2, d2);
        if (m_cnt == SF - 1) begin m_state = S_PLAY; m_cnt = 0; m_dy = 1; end
        else m_cnt++;
      end
      S_PLAY: begin
        m_p1 = pad_move(m_p1, u1, d1); m_p2 = pad_move(m_p2, u2, d2);
        ny = m_by + SPD * m_dy;
        if (m_dy < 0 && ny <= 0) begin ny = 0; m_dy = 1; end
        else if (m_dy > 0 && ny + SZ >= H) begin ny = H - SZ; m_dy = -1; end
        nx = m_bx + SPD * m_dx;
        if (m_dx < 0) begin
          if (m_bx >= P1X && nx <= P1X + PW && overlap(m_by, op1)) begin nx = P1X + PW; m_dx = 1; end
          else if (nx < 0) begin nx = m_bx; if (m_s2 < WIN) m_s2++; m_dx = -1; m_state = S_POINT; end
        end else begin
          if (m_bx + SZ <= P2X + PW && nx + SZ >= P2X && overlap(m_by, op2)) begin nx = P2X - SZ; m_dx = -1; end
          else if (nx + SZ > W) begin nx = m_bx; if (m_s1 < WIN) m_s1++; m_dx = 1; m_state = S_POINT; end
        end
        m_bx = nx; m_by = ny;
      end
      S_POINT: begin
        if (m_s1 == WIN || m_s2 == WIN) m_state = S_OVER;
        else begin m_state = S_SERVE; m_bx = CX; m_by = CY; m_cnt = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic cmp_all();
    chk("state", int'(state), m_state);
    chk("ball_x", int'(ball_x), m_bx);
    chk("ball_y", int'(ball_y), m_by);
    chk("paddle1_y", int'(paddle1_y), m_p1);
    chk("paddle2_y", int'(paddle2_y), m_p2);
    chk("score1", int'(score1), m_s1);
    chk("score2", int'(score2), m_s2);
  endtask

  // One frame: buttons settle through the synchronizer, then one update line
  task automatic do_frame(input bit u1, input bit d1, input bit u2, input bit d2);
    @(negedge clk);
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; btn_start = 1'b0;
    CounterX = 10'd5; CounterY = 9'd100;
    @(negedge clk);
    CounterX = 10'd0; CounterY = 9'd480;
    @(negedge clk);
    CounterX = 10'd1;
    chk("frame_tick_hi", int'(frame_tick), 1);
    @(negedge clk);
    chk("frame_tick_lo", int'(frame_tick), 0);
    m_tick(u1, d1, u2, d2);
    cmp_all();
  endtask

  task automatic do_start();
    @(negedge clk);
    CounterX = 10'd5; CounterY = 9'd100; btn_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("start_not_early", int'(state), m_state);
    @(negedge clk);
    m_start();
    cmp_all();
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct { int cx; int cy; int exp_tick; } tv_t;
  tv_t tv[8];

  initial begin
    #950000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int games;
    bit did_rst;
    bit u1, d1, u2, d2;

    tv[0] = '{0, 480, 1};   tv[1] = '{1, 480, 0};   tv[2] = '{0, 479, 0};
    tv[3] = '{0, 0, 0};     tv[4] = '{639, 480, 0}; tv[5] = '{0, 481, 0};
    tv[6] = '{0, 480, 1};   tv[7] = '{0, 224, 0};

    rst_n = 1'b0; btn_start = 1'b0; p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    CounterX = 10'd5; CounterY = 9'd100;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_ball_x", int'(ball_x), 316);
    chk("rst_ball_y", int'(ball_y), 236);
    chk("rst_paddle1", int'(paddle1_y), 208);
    chk("rst_paddle2", int'(paddle2_y), 208);
    chk("rst_scores", int'(score1) + int'(score2), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    m_reset();

    // Frame tick decode: pulse the cycle after the update position only
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      CounterX = 10'(tv[i].cx); CounterY = 9'(tv[i].cy);
      @(negedge clk);
      chk($sformatf("tick_vec%0d", i), int'(frame_tick), tv[i].exp_tick);
    end
    @(negedge clk);
    CounterX = 10'd5; CounterY = 9'd100;
    chk("idle_after_ticks", int'(state), 0);

    // Start from IDLE, then hold p1_up and both P2 buttons through the serve
    do_start();
    chk("start_to_serve", int'(state), 1);
    for (int f = 0; f < SF - 1; f++) do_frame(1'b1, 1'b0, 1'b1, 1'b1);
    chk("serve_still", int'(state), 1);
    chk("serve_ball_x", int'(ball_x), 316);
    chk("serve_ball_y", int'(ball_y), 236);
    do_frame(1'b1, 1'b0, 1'b1, 1'b1);
    chk("serve_to_play", int'(state), 2);
    chk("p1_clamp_top", int'(paddle1_y), 0);
    chk("p2_both_hold", int'(paddle2_y), 208);

    // Randomized play against the model
    games = 0; did_rst = 1'b0;
    for (int f = 0; f < MAXF && games < 2; f++) begin
      if (m_state == S_OVER) begin
        games++;
        chk("gameover_state", int'(state), 4);
        chk("winner_at_max", int'((score1 == 4'd9) || (score2 == 4'd9)), 1);
        if (games < 2) begin
          do_start();
          chk("restart_scores", int'(score1) + int'(score2), 0);
        end
      end else if (games == 1 && !did_rst && m_state == S_PLAY && (m_s1 + m_s2) >= 1) begin
        did_rst = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        cmp_all();
        chk("midrst_frame_tick", int'(frame_tick), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_start();
      end else if ($urandom_range(0, 299) == 0) begin
        do_start();
      end else begin
        if ($urandom_range(0, 9) < 6) begin
          u1 = (m_p1 + PH / 2 > m_by + SZ / 2);
          d1 = (m_p1 + PH / 2 < m_by + SZ / 2);
        end else begin
          u1 = 1'($urandom_range(0, 1));
          d1 = 1'($urandom_range(0, 1));
        end
        u2 = 1'($urandom_range(0, 1));
        d2 = 1'($urandom_range(0, 1));
        do_frame(u1, d1, u2, d2);
      end
    end
    chk("games_completed", games, 2);
    chk("midrst_done", int'(did_rst), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning): SCREEN_W 640 visible width; SCREEN_H 480 visible height; PADDLE_H 64 paddle height; PADDLE_W 8 paddle width; PADDLE_STEP 4 paddle pixels/frame; BALL_SIZE 8 ball edge; BALL_SPEED 2 ball pixels/frame/axis; P1_X 16 left paddle x; P2_X 616 right paddle x; WIN_SCORE 9 winning score; SERVE_FRAMES 60 serve delay; UPDATE_Y 480 update line.
REQ-002 Ports (name direction width meaning): clk in 1 pixel clock; rst_n in 1 async active-low reset; CounterX in 10 sync-generator column; CounterY in 9 sync-generator row; btn_start in 1 async start button; p1_up, p1_dn, p2_up, p2_dn in 1 each async paddle buttons; ball_x out 10; ball_y out 9; paddle1_y out 9; paddle2_y out 9; score1 out 4; score2 out 4; state out 3; frame_tick out 1.
REQ-003 Single clock domain clk; reset asynchronous, active-low (rst_n).

Function
REQ-004 All five buttons SHALL pass a two-flop synchronizer before use; btn_start additionally edge-detected (rising edge = start_evt, one clk).
REQ-005 frame_tick SHALL be a registered one-clk pulse, asserted the cycle after CounterX==0 && CounterY==UPDATE_Y; all position/score/FSM-counter updates occur only on frame_tick, except REQ-007 start transitions.
REQ-006 FSM encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4; state output = current state.
REQ-007 IDLE: start_evt -> SERVE next clk, scores cleared. GAMEOVER: start_evt -> SERVE next clk, scores cleared, serve direction toward P2.
REQ-008 SERVE: ball held at centre ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2); serve counter increments per tick; on tick where counter==SERVE_FRAMES-1 -> PLAY, counter cleared; dy set +1.
REQ-009 PLAY per tick: ball_x +/- BALL_SPEED per dx, ball_y +/- BALL_SPEED per dy.
REQ-010 Top wall: dy<0 and ball_y<=BALL_SPEED -> ball_y=0, dy=+. Bottom: dy>0 and ball_y+BALL_SIZE+BALL_SPEED>=SCREEN_H -> ball_y=SCREEN_H-BALL_SIZE, dy=-.
REQ-011 Left paddle hit: dx<0, ball_x>=P1_X, ball_x-BALL_SPEED<=P1_X+PADDLE_W, ball_y+BALL_SIZE>paddle1_y, ball_y<paddle1_y+PADDLE_H -> ball_x=P1_X+PADDLE_W, dx=+. Right mirror: dx>0, ball_x+BALL_SIZE<=P2_X+PADDLE_W, ball_x+BALL_SIZE+BALL_SPEED>=P2_X, same vertical test vs paddle2_y -> ball_x=P2_X-BALL_SIZE, dx=-.
REQ-012 Miss: dx<0 and ball_x<BALL_SPEED with no hit -> score2+1, serve direction toward P2's opponent (dx=- next serve), -> POINT; mirror: dx>0 and ball_x+BALL_SIZE+BALL_SPEED>SCREEN_W -> score1+1, next serve dx=+, -> POINT.
REQ-013 Precedence same tick: paddle hit over miss; wall and paddle corrections both apply independently per axis; collision tests use paddle positions before this tick's paddle move.
REQ-014 Paddles move in SERVE and PLAY only: up -> -PADDLE_STEP, dn -> +PADDLE_STEP, both/none -> hold; clamp to [0, SCREEN_H-PADDLE_H], no wrap.
REQ-015 POINT (one tick): if either score==WIN_SCORE -> GAMEOVER, else SERVE with ball recentred. Scores saturate at WIN_SCORE.
REQ-016 All arithmetic SHALL use widths >= 11 bits internally to avoid underflow/overflow before compare; outputs truncated to port width.

Reset
REQ-017 rst_n low: state=IDLE, ball centred (316,236), paddle1_y=paddle2_y=208, scores 0, dx=+, dy=+, serve counter 0, frame_tick 0, synchronizers 0.
REQ-018 rst_n asserted mid-frame/mid-PLAY SHALL take effect immediately; first frame_tick after release follows REQ-005 normally.

Verification
REQ-019 Reset, then free-running counters: frame_tick exactly once per CounterY wrap, one clk wide; state=0.
REQ-020 start pulse in IDLE -> state 1 next clk; after 60 ticks state 2; ball at (316,236) throughout SERVE.
REQ-021 PLAY, ball_y=1, dy=- -> next tick ball_y=0, dy=+; ball_y=471, dy=+ -> ball_y=472.
REQ-022 paddle1_y=200, ball (25,220) dx=- -> ball_x=24, dx=+; same with paddle1_y=300 -> no hit; continue until ball_x<2 -> score2=1, state 3 then 1.
REQ-023 p1_up held 60 frames from 208 -> paddle1_y clamps 0; p2_up+p2_dn both held -> paddle2_y unchanged.
REQ-024 score1=8, right miss -> score1=9, POINT -> GAMEOVER; start -> scores 0, state 1; rst_n low mid-PLAY -> REQ-017 values immediately.
